irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Prioritised interrupt controller directly upstream of the core's i_external_interrupt input.
- Synchronises asynchronous device request lines and latches them in edge or level mode.
- Applies a mask and presents one request at a time through a request/ack/end-of-interrupt handshake.
- o_irq_id tells the handler which source to service.

Parameters:
N_IRQ, 8, number of request lines (2..32)
SYNC_STAGES, 2, flip-flop synchroniser depth per line (>=2)
ID_W, $clog2(N_IRQ), width of o_irq_id

Ports:
i_clk  input  1  system clock, all state on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_irq  input  N_IRQ  raw device request lines, asynchronous to i_clk
i_cfg_we  input  1  configuration write strobe
i_cfg_sel  input  1  0 = mask register, 1 = mode register (1 = edge, 0 = level per line)
i_cfg_data  input  N_IRQ  configuration write data
i_ack  input  1  core has taken the interrupt (one-cycle pulse)
i_eoi  input  1  handler finished (one-cycle pulse)
o_external_interrupt  output  1  request to core, drives the core's i_external_interrupt
o_irq_id  output  ID_W  index of the presented/in-service source
o_pending  output  N_IRQ  current pending vector (before mask)
o_in_service  output  1  high while in SERVICE state

Behaviour:
- Reset (async assert, sync release): synchroniser flops=0; pending=0; mask=0 (all disabled); mode=all edge; state=IDLE; o_external_interrupt=0; o_irq_id=0; o_pending=0; o_in_service=0.
- Synchroniser: SYNC_STAGES flops per line; sync[i] is the last stage; prev[i] holds sync[i] from the previous cycle.
- Edge-mode line: pending[i] sets when sync[i]&~prev[i]; clears only on ack of that id.
- Edge-mode collision: a new edge and an ack clear of the same bit in one cycle leave the bit set (set wins).
- Level-mode line: pending[i]=sync[i] every cycle, with no latching; ack does not clear it.
- Mode change from edge to level drops any latched edge pending for that line.
- o_pending = pending vector.
- Candidate = lowest index i with pending[i]&mask[i]; index 0 has highest priority.
- Config write: registered, takes effect the cycle after the i_cfg_we edge.

State machine (registered outputs):
- IDLE:
  - o_external_interrupt=0.
  - If any candidate: next state REQUEST, o_irq_id<=candidate, o_external_interrupt<=1.
- REQUEST:
  - o_external_interrupt held at 1.
  - o_irq_id re-evaluated each cycle, so a higher-priority arrival pre-empts a not-yet-acked request.
  - If no candidate remains (masked, or level line dropped): return to IDLE, deassert next cycle (withdrawn request).
  - i_ack=1: clear pending[o_irq_id] if edge mode; o_irq_id frozen; go to SERVICE; o_external_interrupt<=0; o_in_service<=1.
  - i_ack and withdrawal in the same cycle: ack wins.
- SERVICE:
  - o_external_interrupt=0; no nesting.
  - i_eoi=1: go to IDLE, o_in_service<=0.
  - New requests keep pending meanwhile and are presented from IDLE afterwards.
  - A level line still high at eoi re-requests.
- Ignored inputs:
  - i_ack outside REQUEST.
  - i_eoi outside SERVICE.
- Latency: i_irq rising before clock edge k (meeting setup) → sync[i]=1 after edge k+SYNC_STAGES-1 → pending after edge k+SYNC_STAGES → o_external_interrupt high after edge k+SYNC_STAGES+1, i.e. 4 edges for default.
- Minimum gap from i_eoi to the next o_external_interrupt: 2 cycles (eoi edge to IDLE, next edge to REQUEST).
- Reset mid-operation: all state returns to reset values immediately. Mask and mode are lost and must be rewritten.
- Width: ID_W computed by $clog2; N_IRQ=1 is unsupported.

Test Plan:
- Reset then mask=8'hFF, mode=8'hFF; pulse i_irq[3] for 1 cycle → o_external_interrupt high 4 edges later, o_irq_id=3, o_pending=8'h08; ack → o_pending=8'h00, o_in_service=1; eoi → IDLE, no re-request.
- Priority: raise i_irq[5] then i_irq[1] one cycle later, before ack → o_irq_id changes 5→1. Ack then eoi → second request presents id 5, o_pending=8'h20.
- Masking: mask=8'hFE, pulse i_irq[0] → o_pending=8'h01, o_external_interrupt stays 0. Then write mask=8'hFF → request asserts 2 cycles after the write edge with id 0.
- Withdrawal and level mode: mode[2]=0 (level), hold i_irq[2] high → request id 2. Drop i_irq[2] before ack → o_external_interrupt falls, state IDLE, ack now ignored. Keep i_irq[2] high through ack/eoi → re-request 2 cycles after eoi.
- Collision and reset: edge on line 4 arriving the same cycle as ack of id 4 → pending[4] stays 1, re-request after eoi. Assert i_rst_n=0 mid-SERVICE → all outputs 0 asynchronously, mask=0 after release.

Source files
------------

// File: rtl/irq_controller_if.sv
// irq_controller_if: request lines, configuration, and core handshake for irq_controller
interface irq_controller_if #(
   parameter int N_IRQ = 8,
   parameter int ID_W  = $clog2(N_IRQ)
);
   logic [N_IRQ-1:0] irq;
   logic             cfg_we;
   logic             cfg_sel;
   logic [N_IRQ-1:0] cfg_data;
   logic             ack;
   logic             eoi;
   logic             external_interrupt;
   logic [ID_W-1:0]  irq_id;
   logic [N_IRQ-1:0] pending;
   logic             in_service;

   modport master (
      output irq, cfg_we, cfg_sel, cfg_data, ack, eoi,
      input  external_interrupt, irq_id, pending, in_service
   );

   modport slave (
      input  irq, cfg_we, cfg_sel, cfg_data, ack, eoi,
      output external_interrupt, irq_id, pending, in_service
   );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: synchronised, prioritised interrupt controller with request/ack/eoi handshake
module irq_controller #(
   parameter int N_IRQ       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = $clog2(N_IRQ)
) (
   input logic             clk,
   input logic             rst_n,
   irq_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

   state_t                            state;
   logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
   logic [N_IRQ-1:0]                  sync, prev, pending, mask, mode, active, clr, nxt;
   logic [ID_W-1:0]                   cand, irq_id;
   logic                              any, ext, in_svc;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign active = pending & mask;
   assign any    = |active;
   // only the presented id is cleared on ack; level lines overwrite it with sync anyway
   assign clr    = (state == REQUEST && bus.ack) ? (N_IRQ'(1) << irq_id) : '0;
   // edge lines latch rises (a rise beats a same-cycle clear); level lines follow sync
   assign nxt    = (mode & ((pending & ~clr) | (sync & ~prev))) | (~mode & sync);

   assign bus.external_interrupt = ext;
   assign bus.irq_id             = irq_id;
   assign bus.pending            = pending;
   assign bus.in_service         = in_svc;

   // lowest pending-and-enabled index wins
   always_comb begin
      cand = '0;
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (active[i]) cand = ID_W'(i);
   end

   // synchronisers, edge history, pending latch and configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev    <= '0;
         pending <= '0;
         mask    <= '0;
         mode    <= '1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.irq};
         prev    <= sync;
         pending <= nxt;
         if (bus.cfg_we && bus.cfg_sel) mode <= bus.cfg_data;
         if (bus.cfg_we && !bus.cfg_sel) mask <= bus.cfg_data;
      end
   end

   // handshake state machine with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ext    <= 1'b0;
         irq_id <= '0;
         in_svc <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any) begin
               state  <= REQUEST;
               irq_id <= cand;
               ext    <= 1'b1;
            end
            REQUEST: if (bus.ack) begin
               state  <= SERVICE;
               ext    <= 1'b0;
               in_svc <= 1'b1;
            end else if (!any) begin
               state <= IDLE;
               ext   <= 1'b0;
            end else begin
               irq_id <= cand;
            end
            SERVICE: if (bus.eoi) begin
               state  <= IDLE;
               in_svc <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scoreboard bench for irq_controller handshake, priority, masking, level mode and reset
module tb_irq_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];

   irq_controller_if #(.N_IRQ(8)) bus ();

   irq_controller #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic sel, input logic [7:0] data);
      bus.cfg_we = 1'b1;
      bus.cfg_sel = sel;
      bus.cfg_data = data;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic pulse_irq(input int line);
      bus.irq[line] = 1'b1;
      tick();
      bus.irq[line] = 1'b0;
   endtask

   task automatic ack_service();
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("ack_req", 32'(bus.external_interrupt), 1);
      check("ack_id", 32'(bus.irq_id), e);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
   endtask

   task automatic end_service();
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
   endtask

   initial begin
      bus.irq = '0;
      bus.cfg_we = 1'b0;
      bus.cfg_sel = 1'b0;
      bus.cfg_data = '0;
      bus.ack = 1'b0;
      bus.eoi = 1'b0;
      tick(3);
      check("rst_ext", 32'(bus.external_interrupt), 0);
      check("rst_id", 32'(bus.irq_id), 0);
      check("rst_pending", 32'(bus.pending), 0);
      check("rst_in_service", 32'(bus.in_service), 0);
      rst_n = 1'b1;
      tick();
      cfg(1'b0, 8'hFF);
      cfg(1'b1, 8'hFF);

      // basic edge request on line 3
      exp_q.push_back(3);
      pulse_irq(3);
      tick(2);
      check("lat_pending", 32'(bus.pending), 32'h08);
      check("lat_ext_early", 32'(bus.external_interrupt), 0);
      tick();
      ack_service();
      check("ack_pending", 32'(bus.pending), 0);
      check("ack_in_service", 32'(bus.in_service), 1);
      check("ack_ext", 32'(bus.external_interrupt), 0);
      end_service();
      check("eoi_in_service", 32'(bus.in_service), 0);
      tick(3);
      check("eoi_no_rereq", 32'(bus.external_interrupt), 0);

      // pre-emption of an unacked request by a higher priority line
      exp_q.push_back(1);
      exp_q.push_back(5);
      pulse_irq(5);
      pulse_irq(1);
      tick(2);
      check("prio_first", 32'(bus.irq_id), 5);
      tick();
      ack_service();
      end_service();
      tick();
      check("prio_second_pending", 32'(bus.pending), 32'h20);
      ack_service();
      end_service();

      // masked line stays pending until enabled
      cfg(1'b0, 8'hFE);
      pulse_irq(0);
      tick(3);
      check("mask_pending", 32'(bus.pending), 32'h01);
      check("mask_no_req", 32'(bus.external_interrupt), 0);
      exp_q.push_back(0);
      cfg(1'b0, 8'hFF);
      check("mask_write_edge", 32'(bus.external_interrupt), 0);
      tick();
      ack_service();
      end_service();

      // level mode: withdrawal, ignored ack, then re-request after eoi
      cfg(1'b1, 8'hFB);
      bus.irq[2] = 1'b1;
      tick(4);
      check("lvl_req", 32'(bus.external_interrupt), 1);
      check("lvl_id", 32'(bus.irq_id), 2);
      bus.irq[2] = 1'b0;
      tick(4);
      check("lvl_withdrawn", 32'(bus.external_interrupt), 0);
      check("lvl_pending_drop", 32'(bus.pending), 0);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      check("lvl_ack_ignored", 32'(bus.in_service), 0);
      bus.irq[2] = 1'b1;
      exp_q.push_back(2);
      tick(4);
      ack_service();
      check("lvl_keep_pending", 32'(bus.pending), 32'h04);
      check("lvl_in_service", 32'(bus.in_service), 1);
      exp_q.push_back(2);
      end_service();
      check("lvl_gap", 32'(bus.external_interrupt), 0);
      tick();
      ack_service();
      bus.irq[2] = 1'b0;
      tick(4);
      end_service();
      tick(2);
      check("lvl_quiet", 32'(bus.external_interrupt), 0);
      cfg(1'b1, 8'hFF);

      // edge arriving with the ack of the same id survives the clear
      exp_q.push_back(4);
      pulse_irq(4);
      tick();
      pulse_irq(4);
      tick();
      ack_service();
      check("coll_pending", 32'(bus.pending), 32'h10);
      exp_q.push_back(4);
      end_service();
      tick();
      ack_service();
      check("coll_cleared", 32'(bus.pending), 0);

      // asynchronous reset while in service
      rst_n = 1'b0;
      #1;
      check("arst_in_service", 32'(bus.in_service), 0);
      check("arst_id", 32'(bus.irq_id), 0);
      check("arst_ext", 32'(bus.external_interrupt), 0);
      tick();
      rst_n = 1'b1;
      tick();
      pulse_irq(6);
      tick(4);
      check("arst_mask_lost_pending", 32'(bus.pending), 32'h40);
      check("arst_mask_lost_ext", 32'(bus.external_interrupt), 0);
      check("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
